// File: rtl/knight_pkg.sv
// Shared encodings, frame counts and screen/hitbox constants for the knight sprite animator.
package knight_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WALK   = 3'd1,
    ST_JUMP   = 3'd2,
    ST_FALL   = 3'd3,
    ST_ATTACK = 3'd4,
    ST_DEAD   = 3'd5
  } status_e;

  typedef enum logic [1:0] {
    A_IDLE,
    A_WINDUP,
    A_SWING,
    A_RECOVER
  } attack_e;

  localparam int FRAMES_IDLE   = 4;
  localparam int FRAMES_WALK   = 6;
  localparam int FRAMES_JUMP   = 2;
  localparam int FRAMES_FALL   = 2;
  localparam int FRAMES_ATTACK = 5;
  localparam int FRAMES_DEAD   = 8;

  localparam int SCREEN_X_MAX = 639;
  localparam int SCREEN_Y_MAX = 479;
  localparam int HIT_OFS      = 15;

  function automatic status_e sanitize(input logic [3:0] raw);
    if (raw > 4'd5) return ST_IDLE;
    return status_e'(raw[2:0]);
  endfunction

  function automatic logic [2:0] last_frame(input status_e s);
    case (s)
      ST_WALK:   return 3'(FRAMES_WALK - 1);
      ST_JUMP:   return 3'(FRAMES_JUMP - 1);
      ST_FALL:   return 3'(FRAMES_FALL - 1);
      ST_ATTACK: return 3'(FRAMES_ATTACK - 1);
      ST_DEAD:   return 3'(FRAMES_DEAD - 1);
      default:   return 3'(FRAMES_IDLE - 1);
    endcase
  endfunction

  function automatic logic [9:0] sat(input logic signed [10:0] v, input logic signed [10:0] lim);
    if (v < 11'sd0) return '0;
    if (v > lim) return lim[9:0];
    return v[9:0];
  endfunction

endpackage

// File: rtl/anim_ticker.sv
// Frame-step divider: counts 0..STEP_TICKS-1 and flags the last tick of each step.
module anim_ticker #(
  parameter int STEP_TICKS = 6
) (
  input  logic frame_clk,
  input  logic Reset,
  input  logic restart,
  output logic step
);

  localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

  logic [TW-1:0] tick;

  // step is taken straight from the count so the parent's restart logic can depend on it
  assign step = (tick == TW'(STEP_TICKS - 1));

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset)                tick <= '0;
    else if (restart || step) tick <= '0;
    else                      tick <= tick + TW'(1);
  end

endmodule

// File: rtl/knight_anim.sv
// Knight sprite animator: sheet/frame sequencing, one-shot attack with hitbox, and death hold.
module knight_anim
  import knight_pkg::*;
#(
  parameter int STEP_TICKS = 6,
  parameter int HIT_W      = 40,
  parameter int HIT_H      = 30
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [3:0] Player_Status,
  input  logic       Inverse,
  input  logic [9:0] PlayerX,
  input  logic [9:0] PlayerY,
  output logic [2:0] Sprite_Sheet,
  output logic [2:0] Frame_Idx,
  output logic       Hit_Active,
  output logic [9:0] Hit_X_Min,
  output logic [9:0] Hit_X_Max,
  output logic [9:0] Hit_Y_Min,
  output logic [9:0] Hit_Y_Max,
  output logic       Attack_Busy,
  output logic       Dead_Done
);

  localparam logic signed [10:0] OFS    = 11'(HIT_OFS);
  localparam logic signed [10:0] W_M1   = 11'(HIT_W - 1);
  localparam logic signed [10:0] H_LO   = 11'(HIT_H / 2);
  localparam logic signed [10:0] H_HI   = 11'(HIT_H / 2 - 1);
  localparam logic signed [10:0] X_LIM  = 11'(SCREEN_X_MAX);
  localparam logic signed [10:0] Y_LIM  = 11'(SCREEN_Y_MAX);

  status_e sheet_q, sheet_n, prev_q, status_s;
  attack_e a_q, a_n;
  logic    facing_q, facing_n;
  logic [2:0] frame_n;
  logic    start, restart, step;
  logic signed [10:0] px, py, x_lo, x_hi, y_lo, y_hi;

  anim_ticker #(.STEP_TICKS(STEP_TICKS)) u_ticker (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .restart   (restart),
    .step      (step)
  );

  always_comb begin
    status_s = sanitize(Player_Status);
    start    = (a_q == A_IDLE) && (status_s == ST_ATTACK) && (prev_q != ST_ATTACK);
    a_n      = a_q;
    facing_n = facing_q;
    if (status_s == ST_DEAD) begin
      a_n = A_IDLE;
    end else begin
      case (a_q)
        A_IDLE:    if (start) begin a_n = A_WINDUP; facing_n = Inverse; end
        A_WINDUP:  if (step && Frame_Idx == 3'd1) a_n = A_SWING;
        A_SWING:   if (step && Frame_Idx == 3'd3) a_n = A_RECOVER;
        A_RECOVER: if (step) a_n = A_IDLE;
        default:   a_n = A_IDLE;
      endcase
    end

    // a held attack status outside a fresh start is displayed as idle
    if (status_s == ST_DEAD)       sheet_n = ST_DEAD;
    else if (a_n != A_IDLE)        sheet_n = ST_ATTACK;
    else if (status_s == ST_ATTACK) sheet_n = ST_IDLE;
    else                           sheet_n = status_s;

    restart = (sheet_n != sheet_q) || start;
    frame_n = Frame_Idx;
    if (restart) begin
      frame_n = 3'd0;
    end else if (step) begin
      if (Frame_Idx == last_frame(sheet_q))
        frame_n = (sheet_q == ST_DEAD) ? Frame_Idx : 3'd0;
      else
        frame_n = Frame_Idx + 3'd1;
    end
  end

  always_comb begin
    px = $signed({1'b0, PlayerX});
    py = $signed({1'b0, PlayerY});
    if (facing_q) begin
      x_hi = px - OFS;
      x_lo = x_hi - W_M1;
    end else begin
      x_lo = px + OFS;
      x_hi = x_lo + W_M1;
    end
    y_lo = py - H_LO;
    y_hi = py + H_HI;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      sheet_q     <= ST_IDLE;
      prev_q      <= ST_IDLE;
      a_q         <= A_IDLE;
      facing_q    <= 1'b0;
      Frame_Idx   <= '0;
      Hit_Active  <= 1'b0;
      Hit_X_Min   <= '0;
      Hit_X_Max   <= '0;
      Hit_Y_Min   <= '0;
      Hit_Y_Max   <= '0;
      Attack_Busy <= 1'b0;
      Dead_Done   <= 1'b0;
    end else begin
      sheet_q     <= sheet_n;
      prev_q      <= status_s;
      a_q         <= a_n;
      facing_q    <= facing_n;
      Frame_Idx   <= frame_n;
      Hit_Active  <= (a_n == A_SWING);
      Hit_X_Min   <= (a_n == A_SWING) ? sat(x_lo, X_LIM) : '0;
      Hit_X_Max   <= (a_n == A_SWING) ? sat(x_hi, X_LIM) : '0;
      Hit_Y_Min   <= (a_n == A_SWING) ? sat(y_lo, Y_LIM) : '0;
      Hit_Y_Max   <= (a_n == A_SWING) ? sat(y_hi, Y_LIM) : '0;
      Attack_Busy <= (a_n != A_IDLE);
      Dead_Done   <= (sheet_n == ST_DEAD) && (frame_n == 3'(FRAMES_DEAD - 1));
    end
  end

  assign Sprite_Sheet = sheet_q;

endmodule

// File: tb/tb_knight_anim.sv
// Directed bench for knight_anim: idle loop, attack timing/hitbox, saturation, death hold, resets.
module tb_knight_anim;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] Player_Status = 4'd0;
  logic       Inverse = 1'b0;
  logic [9:0] PlayerX = 10'd0;
  logic [9:0] PlayerY = 10'd0;
  logic [2:0] Sprite_Sheet, Frame_Idx;
  logic       Hit_Active, Attack_Busy, Dead_Done;
  logic [9:0] Hit_X_Min, Hit_X_Max, Hit_Y_Min, Hit_Y_Max;

  int n_checks = 0;
  int n_errors = 0;

  knight_anim dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .Player_Status (Player_Status),
    .Inverse       (Inverse),
    .PlayerX       (PlayerX),
    .PlayerY       (PlayerY),
    .Sprite_Sheet  (Sprite_Sheet),
    .Frame_Idx     (Frame_Idx),
    .Hit_Active    (Hit_Active),
    .Hit_X_Min     (Hit_X_Min),
    .Hit_X_Max     (Hit_X_Max),
    .Hit_Y_Min     (Hit_Y_Min),
    .Hit_Y_Max     (Hit_Y_Max),
    .Attack_Busy   (Attack_Busy),
    .Dead_Done     (Dead_Done)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge frame_clk);
      #1;
    end
  endtask

  task automatic chk_hit(input string tag, input logic on, input int xl, input int xh,
                         input int yl, input int yh);
    chk({tag, "_act"}, Hit_Active, on);
    chk({tag, "_xmin"}, Hit_X_Min, on ? xl : 0);
    chk({tag, "_xmax"}, Hit_X_Max, on ? xh : 0);
    chk({tag, "_ymin"}, Hit_Y_Min, on ? yl : 0);
    chk({tag, "_ymax"}, Hit_Y_Max, on ? yh : 0);
  endtask

  task automatic chk_zero_all(input string tag);
    chk({tag, "_sheet"}, Sprite_Sheet, 0);
    chk({tag, "_frame"}, Frame_Idx, 0);
    chk({tag, "_busy"}, Attack_Busy, 0);
    chk({tag, "_dead"}, Dead_Done, 0);
    chk_hit(tag, 1'b0, 0, 0, 0, 0);
  endtask

  initial begin
    cyc(2);
    chk_zero_all("reset");
    Reset = 1'b0;

    // idle loops 0,1,2,3,0 with 6 ticks per frame
    for (int i = 0; i < 30; i++) begin
      chk("idle_sheet", Sprite_Sheet, 0);
      chk("idle_frame", Frame_Idx, (i / 6) % 4);
      cyc(1);
    end

    // attack facing right, status held past the end: no retrigger
    PlayerX = 10'd320; PlayerY = 10'd377; Inverse = 1'b0; Player_Status = 4'd4;
    for (int c = 1; c <= 40; c++) begin
      cyc(1);
      chk("atk_busy", Attack_Busy, (c <= 30) ? 1 : 0);
      chk("atk_sheet", Sprite_Sheet, (c <= 30) ? 4 : 0);
      if (c <= 30) chk("atk_frame", Frame_Idx, (c - 1) / 6);
      chk_hit("atk_r", (c >= 13 && c <= 24), 335, 374, 362, 391);
    end
    Player_Status = 4'd0;
    cyc(2);

    // facing left near the left edge; Inverse flipped after start must not matter
    PlayerX = 10'd40; PlayerY = 10'd100; Inverse = 1'b1; Player_Status = 4'd4;
    cyc(1);
    Inverse = 1'b0;
    cyc(11);
    chk("left_c12_act", Hit_Active, 0);
    cyc(1);
    chk_hit("left_c13", 1'b1, 0, 25, 85, 114);
    cyc(11);
    chk_hit("left_c24", 1'b1, 0, 25, 85, 114);
    cyc(1);
    chk("left_c25_act", Hit_Active, 0);
    cyc(5);
    chk("left_c30_busy", Attack_Busy, 1);
    cyc(1);
    chk("left_c31_busy", Attack_Busy, 0);
    Player_Status = 4'd0;
    cyc(2);

    // status drops to walk after 3 cycles; right/bottom saturation
    PlayerX = 10'd620; PlayerY = 10'd5; Inverse = 1'b0; Player_Status = 4'd4;
    cyc(3);
    Player_Status = 4'd1;
    cyc(10);
    chk_hit("sat_c13", 1'b1, 635, 639, 0, 19);
    chk("walk_int_sheet13", Sprite_Sheet, 4);
    cyc(17);
    chk("walk_int_busy30", Attack_Busy, 1);
    chk("walk_int_sheet30", Sprite_Sheet, 4);
    cyc(1);
    chk("walk_int_sheet31", Sprite_Sheet, 1);
    chk("walk_int_frame31", Frame_Idx, 0);
    chk("walk_int_busy31", Attack_Busy, 0);
    cyc(6);
    chk("walk_int_frame37", Frame_Idx, 1);

    // death during swing
    Player_Status = 4'd0;
    cyc(2);
    PlayerX = 10'd320; PlayerY = 10'd377; Player_Status = 4'd4;
    cyc(14);
    chk("die_pre_act", Hit_Active, 1);
    Player_Status = 4'd5;
    cyc(1);
    chk_hit("die_c1", 1'b0, 0, 0, 0, 0);
    chk("die_c1_sheet", Sprite_Sheet, 5);
    chk("die_c1_frame", Frame_Idx, 0);
    chk("die_c1_busy", Attack_Busy, 0);
    cyc(41);
    chk("die_c42_frame", Frame_Idx, 6);
    chk("die_c42_done", Dead_Done, 0);
    cyc(1);
    chk("die_c43_frame", Frame_Idx, 7);
    chk("die_c43_done", Dead_Done, 1);
    cyc(5);
    chk("die_c48_frame", Frame_Idx, 7);
    chk("die_c48_done", Dead_Done, 1);
    cyc(12);
    chk("die_c60_frame", Frame_Idx, 7);
    chk("die_c60_done", Dead_Done, 1);
    chk("die_c60_sheet", Sprite_Sheet, 5);
    Player_Status = 4'd0;
    cyc(1);
    chk("revive_sheet", Sprite_Sheet, 0);
    chk("revive_frame", Frame_Idx, 0);
    chk("revive_done", Dead_Done, 0);

    // two-frame jump loop and out-of-range status
    Player_Status = 4'd2;
    cyc(1);
    chk("jump_sheet", Sprite_Sheet, 2);
    chk("jump_f0", Frame_Idx, 0);
    cyc(6);
    chk("jump_f1", Frame_Idx, 1);
    cyc(6);
    chk("jump_wrap", Frame_Idx, 0);
    Player_Status = 4'd9;
    cyc(1);
    chk("bad_status_sheet", Sprite_Sheet, 0);
    chk("bad_status_frame", Frame_Idx, 0);

    // reset mid-walk at frame 3
    Player_Status = 4'd1;
    cyc(19);
    chk("walk_f3", Frame_Idx, 3);
    chk("walk_sheet", Sprite_Sheet, 1);
    Reset = 1'b1;
    #2;
    chk_zero_all("rst_walk");
    cyc(2);
    Reset = 1'b0;
    cyc(1);
    chk("walk_restart_sheet", Sprite_Sheet, 1);
    chk("walk_restart_frame", Frame_Idx, 0);
    cyc(6);
    chk("walk_restart_f1", Frame_Idx, 1);

    // reset mid-swing
    Player_Status = 4'd0;
    cyc(2);
    Player_Status = 4'd4;
    cyc(14);
    chk("rst_atk_pre", Hit_Active, 1);
    Reset = 1'b1;
    #2;
    chk_zero_all("rst_atk");
    Player_Status = 4'd0;
    cyc(1);
    Reset = 1'b0;
    cyc(1);
    chk_zero_all("rst_atk_after");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
